pl_stage_mem: RTL and testbench
===============================

# pl_stage_mem

Memory stage of the 5-stage pipeline, directly downstream of the execute stage. It consumes the EXE/MEM-registered ALU result and store data, and runs a valid/ready transaction on the data-memory bus with a bounded wait. Load data is aligned and extended here. The block contains the MEM/WB pipeline register that feeds write-back, and it produces the pipeline stall while a memory access is outstanding.

## Interface
Parameters:
- TIMEOUT, 16: maximum number of cycles `dreq` is held without `dready` before the access is aborted; legal range 2..255.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mvalid  in  1  an instruction occupies MEM.
- malu  in  32  execute result; the effective address for loads and stores.
- mb  in  32  store data (rs2).
- mwmem  in  1  store.
- mm2reg  in  1  load.
- mfunct3  in  3  access size and signedness.
- mwreg  in  1  writes a destination register.
- mrn  in  5  destination register.
- dreq  out  1  bus request.
- dwe  out  1  bus write.
- daddr  out  32  word address, equal to {malu[31:2],2'b00}.
- dwdata  out  32  lane-replicated store data.
- dbe  out  4  byte enables.
- drdata  in  32  read data, valid when dready is high.
- dready  in  1  the access completes in this cycle.
- mstall  out  1  holds the PC, IF/ID, ID/EXE and EXE/MEM registers.
- wvalid, wwreg  out  1 each  MEM/WB register.
- wrn  out  5  MEM/WB register.
- wd  out  32  MEM/WB register; the write-back value.
- wexc  out  1  one-cycle exception flag in MEM/WB.
- wcause  out  2  exception cause: 01 = misaligned or illegal size, 10 = bus timeout.

## Operation
- An access is a memory operation, `memop = mvalid & (mwmem | mm2reg)`.
- Size checks:
  - Legal loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Legal stores: SB 000, SH 001, SW 010.
  - Misaligned: H or HU with malu[0]=1; W with malu[1:0]≠0.
  - Illegal: any other funct3 on a memop.
  - A misaligned or illegal access never asserts dreq.
- FSM has two states, IDLE and WAIT. `cnt` is an 8-bit wait counter.
  - In IDLE, dreq = memop & legal, combinationally, so a zero-wait access issues and completes in the same cycle.
  - IDLE → WAIT when dreq & !dready; cnt becomes 1.
  - In WAIT, dreq = 1. On dready: → IDLE, cnt = 0. Otherwise cnt increments.
  - Abort: if dreq & !dready with cnt == TIMEOUT-1, go to IDLE and clear cnt.
- mstall = dreq & !dready & !abort.
- Stores:
  - dwe = mwmem.
  - dwdata: SB uses {4{mb[7:0]}}; SH uses {2{mb[15:0]}}; SW uses mb.
  - dbe: SB uses 0001<<malu[1:0]; SH uses 0011<<{malu[1],1'b0}; SW uses 1111.
  - Loads use dbe = 1111.
- Load alignment: select the byte or halfword lane of drdata using malu[1:0]. Sign-extend for LB and LH, zero-extend for LBU and LHU.
- MEM/WB update on every non-stalled cycle:
  - Normal instruction: wvalid = mvalid & !fault; wwreg = mwreg & !fault; wrn = mrn; wd = mm2reg ? aligned load : malu.
  - Fault (misaligned, illegal or abort): wvalid = 0, wwreg = 0, wexc = 1, wcause set to the matching code.
  - Stalled cycle: the MEM/WB register loads a bubble (wvalid = 0, wwreg = 0, wexc = 0).
- Upstream registers must hold every m* input stable while mstall is high. The block does not capture those inputs.

## Timing
- Reset, asynchronous:
  - State IDLE, cnt = 0.
  - wvalid, wwreg, wexc = 0; wrn = 0; wd = 0; wcause = 00.
  - dreq follows mvalid. The EXE/MEM register is reset by the same rst, so dreq is 0.
- Reset during WAIT drops dreq immediately. The bus must tolerate the abandoned request.
- Latency:
  - A zero-wait access reaches MEM/WB at the next edge.
  - N wait cycles add N stall cycles.
- Handshake: a transfer occurs only on a clock edge with dreq & dready both high.
- Timeout: dreq stays high for at most TIMEOUT consecutive cycles. The last of them is the abort cycle, with mstall = 0; wexc rises at the following edge.
- wexc is high for exactly one cycle per fault.
- Back-to-back accesses: IDLE is re-entered on completion, so the next memop issues dreq in the cycle after the previous access completes.

## Test plan
- LW, malu = 0x100, dready tied high, drdata = 0xDEADBEEF → dreq for 1 cycle, mstall never asserted, wd = 0xDEADBEEF, wvalid = 1.
- LB, malu = 0x103, drdata = 0x80FF_0000, 2 wait cycles → mstall high for 2 cycles, wd = 0xFFFFFF80. LBU with the same inputs → wd = 0x00000080.
- SH, malu = 0x202, mb = 0x1234ABCD → dbe = 1100, dwdata = 0xABCDABCD, dwe = 1, wwreg = 0.
- LW, malu = 0x101 → dreq never asserted, mstall = 0, wexc = 1 for one cycle with wcause = 01, wwreg = 0.
- TIMEOUT = 4, LW with dready held low → dreq high for 4 cycles, mstall high for 3, wexc = 1 with wcause = 10, and the FSM returns to IDLE.
- rst pulsed during WAIT → dreq, wvalid, wexc and cnt all read 0 asynchronously; after release, a new LW completes normally.

Source files
------------

// File: rtl/pl_stage_mem.sv
// rtl/pl_stage_mem.sv - memory stage: bounded-wait data bus access, load alignment, MEM/WB register
module pl_stage_mem #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mvalid,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  input  logic        mwmem,
  input  logic        mm2reg,
  input  logic [2:0]  mfunct3,
  input  logic        mwreg,
  input  logic [4:0]  mrn,
  output logic        dreq,
  output logic        dwe,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  dbe,
  input  logic [31:0] drdata,
  input  logic        dready,
  output logic        mstall,
  output logic        wvalid,
  output logic        wwreg,
  output logic [4:0]  wrn,
  output logic [31:0] wd,
  output logic        wexc,
  output logic [1:0]  wcause
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wvalid_q, wvalid_d, wwreg_q, wwreg_d, wexc_q, wexc_d;
  logic [4:0]  wrn_q, wrn_d;
  logic [31:0] wd_q, wd_d;
  logic [1:0]  wcause_q, wcause_d;

  logic        memop, size_ok, misal, align_fault, abort, fault;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    memop = mvalid & (mwmem | mm2reg);
    if (mwmem) size_ok = (mfunct3 == 3'b000) | (mfunct3 == 3'b001) | (mfunct3 == 3'b010);
    else       size_ok = (mfunct3 == 3'b000) | (mfunct3 == 3'b001) | (mfunct3 == 3'b010) |
                         (mfunct3 == 3'b100) | (mfunct3 == 3'b101);
    misal = ((mfunct3[1:0] == 2'b01) & malu[0]) | ((mfunct3[1:0] == 2'b10) & (|malu[1:0]));
    align_fault = memop & (~size_ok | misal);
    // Inputs are held stable during WAIT, so the request stays asserted there unconditionally.
    dreq   = (state_q == WAIT) | (memop & size_ok & ~misal);
    abort  = dreq & ~dready & (cnt_q == CNT_LAST);
    mstall = dreq & ~dready & ~abort;
    fault  = align_fault | abort;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (dreq) begin
      if (dready || abort) begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end else begin
        state_d = WAIT;
        cnt_d   = cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    dwe    = mwmem;
    daddr  = {malu[31:2], 2'b00};
    dwdata = mb;
    dbe    = 4'b1111;
    case (mfunct3[1:0])
      2'b00: begin
        dwdata = {4{mb[7:0]}};
        if (mwmem) dbe = 4'b0001 << malu[1:0];
      end
      2'b01: begin
        dwdata = {2{mb[15:0]}};
        if (mwmem) dbe = 4'b0011 << {malu[1], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (malu[1:0])
      2'b00:   ld_byte = drdata[7:0];
      2'b01:   ld_byte = drdata[15:8];
      2'b10:   ld_byte = drdata[23:16];
      default: ld_byte = drdata[31:24];
    endcase
    ld_half = malu[1] ? drdata[31:16] : drdata[15:0];
    case (mfunct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = drdata;
    endcase
  end

  always_comb begin
    wvalid_d = wvalid_q;
    wwreg_d  = wwreg_q;
    wexc_d   = wexc_q;
    wrn_d    = wrn_q;
    wd_d     = wd_q;
    wcause_d = wcause_q;
    if (mstall) begin
      wvalid_d = 1'b0;
      wwreg_d  = 1'b0;
      wexc_d   = 1'b0;
    end else begin
      wvalid_d = mvalid & ~fault;
      wwreg_d  = mwreg & ~fault;
      wexc_d   = fault;
      wrn_d    = mrn;
      wd_d     = mm2reg ? ld_data : malu;
      wcause_d = abort ? 2'b10 : (align_fault ? 2'b01 : 2'b00);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      wvalid_q <= 1'b0;
      wwreg_q  <= 1'b0;
      wexc_q   <= 1'b0;
      wrn_q    <= 5'd0;
      wd_q     <= 32'd0;
      wcause_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wvalid_q <= wvalid_d;
      wwreg_q  <= wwreg_d;
      wexc_q   <= wexc_d;
      wrn_q    <= wrn_d;
      wd_q     <= wd_d;
      wcause_q <= wcause_d;
    end
  end

  assign wvalid = wvalid_q;
  assign wwreg  = wwreg_q;
  assign wexc   = wexc_q;
  assign wrn    = wrn_q;
  assign wd     = wd_q;
  assign wcause = wcause_q;

endmodule

// File: tb/tb_pl_stage_mem.sv
// tb/tb_pl_stage_mem.sv - randomized bench for pl_stage_mem against a byte-level reference model
module tb_pl_stage_mem;
  localparam int TO = 4;

  logic        clk, rst;
  logic        mvalid, mwmem, mm2reg, mwreg;
  logic [31:0] malu, mb, drdata;
  logic [2:0]  mfunct3;
  logic [4:0]  mrn;
  logic        dreq, dwe, dready, mstall, wvalid, wwreg, wexc;
  logic [31:0] daddr, dwdata, wd;
  logic [3:0]  dbe;
  logic [4:0]  wrn;
  logic [1:0]  wcause;

  pl_stage_mem #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mvalid(mvalid), .malu(malu), .mb(mb), .mwmem(mwmem),
    .mm2reg(mm2reg), .mfunct3(mfunct3), .mwreg(mwreg), .mrn(mrn), .dreq(dreq),
    .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .dbe(dbe), .drdata(drdata),
    .dready(dready), .mstall(mstall), .wvalid(wvalid), .wwreg(wwreg), .wrn(wrn),
    .wd(wd), .wexc(wexc), .wcause(wcause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic int m_nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit m_ok(input bit wm, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    int off;
    if (wm) legal = (f3 <= 3'd2);
    else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    off = int'(a[1:0]);
    return legal && (off % m_nbytes(f3) == 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int off, v, n;
    bit sgn;
    off = int'(a[1:0]);
    n   = m_nbytes(f3);
    sgn = (f3[2] == 1'b0);
    if (n == 4) return rd;
    v = 0;
    for (int i = n - 1; i >= 0; i--) v = v * 256 + int'(rd[8*(off+i) +: 8]);
    if (sgn && v >= (1 << (8*n - 1))) v = v - (1 << (8*n));
    return 32'(v);
  endfunction

  function automatic logic [3:0] m_be(input bit wm, input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] be;
    int off, n;
    if (!wm) return 4'hF;
    be  = 4'h0;
    off = int'(a[1:0]);
    n   = m_nbytes(f3);
    for (int i = 0; i < n; i++) be[off + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] b);
    logic [31:0] w;
    int n;
    n = m_nbytes(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = b[8*(i % n) +: 8];
    return w;
  endfunction

  // One instruction held in MEM until it leaves; the bus answers after w wait cycles (w >= TO never answers).
  task automatic run(input bit v, input bit wm, input bit lr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] b, input bit wr,
                     input logic [4:0] rn, input int w, input logic [31:0] rdv);
    bit memop, ok, exp_dreq, completes, abort, fault;
    logic [31:0] rd;
    mvalid = v; mwmem = wm; mm2reg = lr; mfunct3 = f3; malu = a; mb = b; mwreg = wr; mrn = rn;
    memop = v && (wm || lr);
    ok    = m_ok(wm, f3, a);
    exp_dreq = memop && ok;
    for (int k = 0; k < TO + 2; k++) begin
      rd = (k == w) ? rdv : $urandom;
      dready = (k == w);
      drdata = rd;
      #2;
      completes = !exp_dreq || (k == w);
      abort     = exp_dreq && !completes && (k == TO - 1);
      check("dreq", 32'(dreq), 32'(exp_dreq));
      check("mstall", 32'(mstall), 32'(exp_dreq && !completes && !abort));
      if (exp_dreq && k == 0) begin
        check("daddr", daddr, {a[31:2], 2'b00});
        check("dwe", 32'(dwe), 32'(wm));
        check("dbe", 32'(dbe), 32'(m_be(wm, f3, a)));
        if (wm) check("dwdata", dwdata, m_wdata(f3, b));
      end
      @(posedge clk);
      #1;
      if (completes) begin
        fault = memop && !ok;
        check("wvalid", 32'(wvalid), 32'(v && !fault));
        check("wwreg", 32'(wwreg), 32'(wr && !fault));
        check("wexc", 32'(wexc), 32'(fault));
        if (fault) check("wcause_align", 32'(wcause), 32'd1);
        else if (v) begin
          check("wrn", 32'(wrn), 32'(rn));
          check("wd", wd, lr ? m_load(f3, a, rd) : a);
        end
        return;
      end else if (abort) begin
        check("wexc_to", 32'(wexc), 32'd1);
        check("wcause_to", 32'(wcause), 32'd2);
        check("wvalid_to", 32'(wvalid), 32'd0);
        check("wwreg_to", 32'(wwreg), 32'd0);
        return;
      end else begin
        check("wvalid_bubble", 32'(wvalid), 32'd0);
        check("wexc_bubble", 32'(wexc), 32'd0);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    mvalid = 0; mwmem = 0; mm2reg = 0; mwreg = 0; mfunct3 = 0; mrn = 0;
    malu = 0; mb = 0; drdata = 0; dready = 0;
    #3;
    check("rst_wvalid", 32'(wvalid), 32'd0);
    check("rst_wwreg", 32'(wwreg), 32'd0);
    check("rst_wexc", 32'(wexc), 32'd0);
    check("rst_wrn", 32'(wrn), 32'd0);
    check("rst_wd", wd, 32'd0);
    check("rst_wcause", 32'(wcause), 32'd0);
    check("rst_dreq", 32'(dreq), 32'd0);
    check("rst_mstall", 32'(mstall), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run(1, 0, 1, 3'b010, 32'h100, 32'h0, 1, 5'd3, 0, 32'hDEADBEEF);
    run(1, 0, 1, 3'b000, 32'h103, 32'h0, 1, 5'd4, 2, 32'h80FF0000);
    run(1, 0, 1, 3'b100, 32'h103, 32'h0, 1, 5'd5, 2, 32'h80FF0000);
    run(1, 1, 0, 3'b001, 32'h202, 32'h1234ABCD, 0, 5'd0, 1, 32'h0);
    run(1, 0, 1, 3'b010, 32'h101, 32'h0, 1, 5'd6, 0, 32'h0);
    run(1, 0, 1, 3'b010, 32'h104, 32'h0, 1, 5'd7, 99, 32'h0);
    run(1, 0, 1, 3'b101, 32'h106, 32'h0, 1, 5'd8, TO - 1, 32'h9876ABCD);
    run(1, 0, 0, 3'b000, 32'h12345678, 32'h0, 1, 5'd9, 0, 32'h0);
    run(1, 1, 0, 3'b011, 32'h200, 32'h0, 0, 5'd0, 0, 32'h0);

    mvalid = 1; mm2reg = 1; mwmem = 0; mfunct3 = 3'b010; malu = 32'h300; dready = 0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("pre_rst_dreq", 32'(dreq), 32'd1);
    rst = 1'b1;
    mvalid = 0; mm2reg = 0;
    #1;
    check("arst_dreq", 32'(dreq), 32'd0);
    check("arst_wvalid", 32'(wvalid), 32'd0);
    check("arst_wexc", 32'(wexc), 32'd0);
    check("arst_cnt", 32'(dut.cnt_q), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(1, 0, 1, 3'b010, 32'h400, 32'h0, 1, 5'd10, 1, 32'hCAFEF00D);

    for (int i = 0; i < 300; i++) begin
      bit v, wm, lr;
      int kind;
      v    = ($urandom_range(0, 9) != 0);
      kind = $urandom_range(0, 2);
      wm   = (kind == 2);
      lr   = (kind == 1);
      run(v, wm, lr, 3'($urandom_range(0, 7)), $urandom, $urandom, v ? 1'($urandom) : 1'b0,
          5'($urandom), $urandom_range(0, TO + 1), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
